// File: rtl/next_pc_stage.sv
// rtl/next_pc_stage.sv - fetch PC register and next-group PC selection
//
// Purpose:
//   Owns the fetch PC. Each cycle it presents one FETCH_WIDTH-instruction group to
//   Fetch/BTB/I-cache and selects the next group PC from these sources, highest
//   priority first: recovery, pre-decode redirect, stall hold, BTB taken, sequential.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   recoveryValid/PC         backend recovery request and target
//   decRedirect/PC           pre-decode redirect request and target
//   stall                    downstream cannot accept the group (holds PC)
//   haltReq                  stop fetching until the next redirect
//   btbHit, brPredTaken      per-slot BTB hit and predicted direction
//   btbOut                   per-slot BTB targets, slot i at [i*PC_WIDTH +: PC_WIDTH]
//   fetchStagePC             per-slot PCs, slot i = group base + i*INSN_BYTES
//   fetchStageIsValid        per-slot valid
//   icReadAddr               current (possibly mid-group) fetch PC
//   running                  fetch is in the RUN state

module next_pc_stage #(
  parameter int                  FETCH_WIDTH = 2,
  parameter int                  PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h0000_1000,
  parameter int                  INSN_BYTES  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            recoveryValid,
  input  logic [PC_WIDTH-1:0]             recoveryPC,
  input  logic                            decRedirect,
  input  logic [PC_WIDTH-1:0]             decRedirectPC,
  input  logic                            stall,
  input  logic                            haltReq,
  input  logic [FETCH_WIDTH-1:0]          btbHit,
  input  logic [FETCH_WIDTH-1:0]          brPredTaken,
  input  logic [FETCH_WIDTH*PC_WIDTH-1:0] btbOut,
  output logic [FETCH_WIDTH*PC_WIDTH-1:0] fetchStagePC,
  output logic [FETCH_WIDTH-1:0]          fetchStageIsValid,
  output logic [PC_WIDTH-1:0]             icReadAddr,
  output logic                            running
);

  localparam int                  GROUP_BYTES = FETCH_WIDTH * INSN_BYTES;
  localparam int                  INSN_SHIFT  = $clog2(INSN_BYTES);
  localparam logic [PC_WIDTH-1:0] GB_PC       = PC_WIDTH'(GROUP_BYTES);
  localparam logic [PC_WIDTH-1:0] GB_MASK     = GB_PC - 1'b1;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_HALTED
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc_reg;

  logic [PC_WIDTH-1:0] group_base;
  logic [PC_WIDTH-1:0] start_slot;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] btb_target;
  logic                btb_taken;
  logic                active;
  logic                redir_valid;
  logic [PC_WIDTH-1:0] redir_pc;

  assign group_base = pc_reg & ~GB_MASK;
  // Slots before the entry point of an unaligned group are never issued.
  assign start_slot = (pc_reg & GB_MASK) >> INSN_SHIFT;
  // Wraps silently at the top of the address space.
  assign seq_pc     = group_base + GB_PC;

  // Reset forces outputs idle immediately, even if the state register still reads RUN.
  assign active     = (state == ST_RUN) && !rst;
  assign running    = active;
  assign icReadAddr = pc_reg;

  // Recovery beats pre-decode; a losing decRedirect is simply dropped.
  assign redir_valid = recoveryValid || decRedirect;
  assign redir_pc    = recoveryValid ? recoveryPC : decRedirectPC;

  // Walk the slots in order: a slot is valid from the entry point up to and including
  // the first predicted-taken branch; that branch also supplies the BTB target.
  always_comb begin
    fetchStagePC      = '0;
    fetchStageIsValid = '0;
    btb_taken         = 1'b0;
    btb_target        = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      fetchStagePC[i*PC_WIDTH +: PC_WIDTH] = group_base + PC_WIDTH'(i * INSN_BYTES);
      if (active && (PC_WIDTH'(i) >= start_slot) && !btb_taken) begin
        fetchStageIsValid[i] = 1'b1;
        if (btbHit[i] && brPredTaken[i]) begin
          btb_taken  = 1'b1;
          btb_target = btbOut[i*PC_WIDTH +: PC_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
      state  <= ST_INIT;
    end else begin
      case (state)
        ST_INIT: begin
          // A redirect arriving before the first group replaces RESET_PC.
          if (redir_valid) begin
            pc_reg <= redir_pc;
          end
          state <= ST_RUN;
        end

        ST_RUN: begin
          if (redir_valid) begin
            // A redirect is honoured even while stalled; it also cancels a halt request.
            pc_reg <= redir_pc;
          end else begin
            if (!stall) begin
              pc_reg <= btb_taken ? btb_target : seq_pc;
            end
            if (haltReq) begin
              state <= ST_HALTED;
            end
          end
        end

        ST_HALTED: begin
          if (redir_valid) begin
            pc_reg <= redir_pc;
            state  <= ST_RUN;
          end
        end

        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_next_pc_stage.sv
// tb/tb_next_pc_stage.sv - self-checking bench for next_pc_stage
module tb_next_pc_stage;

  localparam int FW = 2;
  localparam int PW = 32;
  localparam int IB = 4;
  localparam int GB = FW * IB;
  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          recoveryValid;
  logic [PW-1:0] recoveryPC;
  logic          decRedirect;
  logic [PW-1:0] decRedirectPC;
  logic          stall;
  logic          haltReq;
  logic [FW-1:0] btbHit;
  logic [FW-1:0] brPredTaken;
  logic [FW*PW-1:0] btbOut;
  logic [FW*PW-1:0] fetchStagePC;
  logic [FW-1:0] fetchStageIsValid;
  logic [PW-1:0] icReadAddr;
  logic          running;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  next_pc_stage #(
    .FETCH_WIDTH(FW),
    .PC_WIDTH   (PW),
    .RESET_PC   (RST_PC),
    .INSN_BYTES (IB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .recoveryValid    (recoveryValid),
    .recoveryPC       (recoveryPC),
    .decRedirect      (decRedirect),
    .decRedirectPC    (decRedirectPC),
    .stall            (stall),
    .haltReq          (haltReq),
    .btbHit           (btbHit),
    .brPredTaken      (brPredTaken),
    .btbOut           (btbOut),
    .fetchStagePC     (fetchStagePC),
    .fetchStageIsValid(fetchStageIsValid),
    .icReadAddr       (icReadAddr),
    .running          (running)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        dr;
    logic [31:0] dpc;
    logic        st;
    logic        hq;
    logic [1:0]  hit;
    logic [1:0]  tk;
    logic [31:0] b0;
    logic [31:0] b1;
    logic [31:0] e_addr;
    logic [1:0]  e_val;
    logic        e_run;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic rv, input logic [31:0] rpc,
                     input logic dr, input logic [31:0] dpc, input logic st, input logic hq,
                     input logic [1:0] hit, input logic [1:0] tk,
                     input logic [31:0] b0, input logic [31:0] b1,
                     input logic [31:0] ea, input logic [1:0] ev, input logic er);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.dr = dr; v.dpc = dpc; v.st = st; v.hq = hq;
    v.hit = hit; v.tk = tk; v.b0 = b0; v.b1 = b1;
    v.e_addr = ea; v.e_val = ev; v.e_run = er;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    rst = 1'b0; recoveryValid = 1'b0; recoveryPC = '0; decRedirect = 1'b0;
    decRedirectPC = '0; stall = 1'b0; haltReq = 1'b0; btbHit = '0; brPredTaken = '0;
    btbOut = '0;
  endtask

  // Expected group outputs given the fetch address; slot PCs derive from the group base.
  task automatic chk_group(input string tag, input logic [31:0] addr, input logic [1:0] val,
                           input logic run);
    logic [31:0] base;
    base = addr - (addr % GB);
    chk({tag, ".addr"}, icReadAddr, addr);
    chk({tag, ".valid"}, fetchStageIsValid, val);
    chk({tag, ".running"}, running, run);
    chk({tag, ".slot0"}, fetchStagePC[31:0], base);
    chk({tag, ".slot1"}, fetchStagePC[63:32], base + IB);
  endtask

  // Reference model: architectural fetch PC and a 3-way mode (0 init, 1 run, 2 halted).
  logic [31:0] m_pc;
  int          m_mode;

  task automatic model_outputs(output logic [1:0] val, output logic taken,
                               output logic [31:0] tgt);
    int start;
    val = 2'b00; taken = 1'b0; tgt = '0;
    start = int'(m_pc % GB) / IB;
    if (!rst && m_mode == 1) begin
      for (int s = 0; s < FW; s++) begin
        if (s >= start && !taken) begin
          val[s] = 1'b1;
          if (btbHit[s] && brPredTaken[s]) begin
            taken = 1'b1;
            tgt   = btbOut[s*PW +: PW];
          end
        end
      end
    end
  endtask

  task automatic model_step(input logic taken, input logic [31:0] tgt);
    logic [31:0] redir;
    redir = recoveryValid ? recoveryPC : decRedirectPC;
    if (rst) begin
      m_pc = RST_PC; m_mode = 0;
    end else if (m_mode == 0) begin
      if (recoveryValid || decRedirect) m_pc = redir;
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (recoveryValid || decRedirect) m_pc = redir;
      else begin
        if (!stall) m_pc = taken ? tgt : (m_pc - (m_pc % GB)) + GB;
        if (haltReq) m_mode = 2;
      end
    end else begin
      if (recoveryValid || decRedirect) begin
        m_pc = redir; m_mode = 1;
      end
    end
  endtask

  function automatic logic [31:0] rnd_pc();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'hFFFF_FFF8;
    if (k == 1) return 32'hFFFF_FFFC;
    return $urandom() & 32'hFFFF_FFFC;
  endfunction

  initial begin
    vec_t v;
    logic [1:0]  ev;
    logic        et;
    logic [31:0] etgt;

    clear_inputs();
    rst = 1'b1;

    //   rst rv rpc          dr dpc       st hq hit tk b0         b1         addr          val run
    add(1, 0, 0,            0, 0,        0, 0, 0, 0, 0,         0,         32'h1000,     0, 0);
    add(1, 0, 0,            0, 0,        0, 0, 0, 0, 0,         0,         32'h1000,     0, 0);
    add(1, 0, 0,            0, 0,        0, 0, 0, 0, 0,         0,         32'h1000,     0, 0);
    add(0, 0, 0,            0, 0,        0, 0, 0, 0, 0,         0,         32'h1000,     0, 0);
    add(0, 0, 0,            0, 0,        0, 0, 0, 0, 0,         0,         32'h1000,     3, 1);
    add(0, 0, 0,            0, 0,        0, 0, 0, 0, 0,         0,         32'h1008,     3, 1);
    add(0, 0, 0,            0, 0,        0, 0, 0, 0, 0,         0,         32'h1010,     3, 1);
    add(0, 1, 32'h1004,     0, 0,        0, 0, 0, 0, 0,         0,         32'h1018,     3, 1);
    add(0, 0, 0,            0, 0,        0, 0, 0, 0, 0,         0,         32'h1004,     2, 1);
    add(0, 1, 32'h2000,     0, 0,        0, 0, 0, 0, 0,         0,         32'h1008,     3, 1);
    add(0, 0, 0,            0, 0,        0, 0, 1, 1, 32'h3004,  0,         32'h2000,     1, 1);
    add(0, 0, 0,            0, 0,        0, 0, 0, 0, 0,         0,         32'h3004,     2, 1);
    add(0, 1, 32'h2008,     0, 0,        0, 0, 0, 0, 0,         0,         32'h3008,     3, 1);
    add(0, 0, 0,            0, 0,        1, 0, 0, 0, 0,         0,         32'h2008,     3, 1);
    add(0, 1, 32'h4000,     0, 0,        1, 0, 0, 0, 0,         0,         32'h2008,     3, 1);
    add(0, 1, 32'h5000,     1, 32'h6000, 0, 0, 0, 0, 0,         0,         32'h4000,     3, 1);
    add(0, 0, 0,            0, 0,        0, 1, 0, 0, 0,         0,         32'h5000,     3, 1);
    add(0, 0, 0,            0, 0,        0, 1, 0, 0, 0,         0,         32'h5008,     0, 0);
    add(0, 0, 0,            0, 0,        0, 0, 3, 3, 32'h1234,  0,         32'h5008,     0, 0);
    add(0, 0, 0,            0, 0,        0, 1, 0, 0, 0,         0,         32'h5008,     0, 0);
    add(0, 0, 0,            0, 0,        0, 0, 0, 0, 0,         0,         32'h5008,     0, 0);
    add(0, 0, 0,            1, 32'h7000, 0, 0, 0, 0, 0,         0,         32'h5008,     0, 0);
    add(0, 1, 32'hFFFFFFF8, 0, 0,        0, 0, 0, 0, 0,         0,         32'h7000,     3, 1);
    add(0, 0, 0,            0, 0,        0, 0, 0, 0, 0,         0,         32'hFFFFFFF8, 3, 1);
    add(0, 0, 0,            0, 0,        0, 0, 3, 2, 32'hBAD0,  32'h8000,  32'h0000,     3, 1);
    add(0, 1, 32'h9004,     0, 0,        0, 0, 0, 0, 0,         0,         32'h8000,     3, 1);
    add(0, 0, 0,            0, 0,        0, 0, 1, 1, 32'hAAA0,  0,         32'h9004,     2, 1);
    add(1, 1, 32'hB000,     0, 0,        0, 0, 0, 0, 0,         0,         32'h9008,     0, 0);
    add(0, 1, 32'hC000,     0, 0,        0, 0, 0, 0, 0,         0,         32'h1000,     0, 0);
    add(0, 0, 0,            0, 0,        0, 0, 0, 0, 0,         0,         32'hC000,     3, 1);

    for (int n = 0; n < vq.size(); n++) begin
      v = vq[n];
      rst = v.rst; recoveryValid = v.rv; recoveryPC = v.rpc; decRedirect = v.dr;
      decRedirectPC = v.dpc; stall = v.st; haltReq = v.hq; btbHit = v.hit;
      brPredTaken = v.tk; btbOut = {v.b1, v.b0};
      @(negedge clk);
      chk_group($sformatf("vec%0d", n), v.e_addr, v.e_val, v.e_run);
      @(posedge clk); #1;
    end

    // Halt request loses to a same-cycle decRedirect.
    clear_inputs();
    haltReq = 1'b1; decRedirect = 1'b1; decRedirectPC = 32'hD000;
    @(negedge clk); chk_group("halt_vs_dec.pre", 32'hC008, 2'b11, 1'b1);
    @(posedge clk); #1; clear_inputs();
    @(negedge clk); chk_group("halt_vs_dec.post", 32'hD000, 2'b11, 1'b1);
    // Halt together with stall: PC held, fetch stops.
    haltReq = 1'b1; stall = 1'b1;
    @(posedge clk); #1; clear_inputs();
    @(negedge clk); chk_group("halt_stall", 32'hD000, 2'b00, 1'b0);
    // Recovery while halted and stalled still restarts at its target next cycle.
    recoveryValid = 1'b1; recoveryPC = 32'hE004; stall = 1'b1;
    @(posedge clk); #1; clear_inputs();
    @(negedge clk); chk_group("halt_recover", 32'hE004, 2'b10, 1'b1);
    @(posedge clk); #1;

    // Randomised run against the reference model.
    rst = 1'b1;
    @(posedge clk); #1;
    m_pc = RST_PC; m_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 59) == 0);
      recoveryValid = ($urandom_range(0, 9) == 0);
      recoveryPC    = rnd_pc();
      decRedirect   = ($urandom_range(0, 9) == 0);
      decRedirectPC = rnd_pc();
      stall         = ($urandom_range(0, 3) == 0);
      haltReq       = ($urandom_range(0, 14) == 0);
      btbHit        = FW'($urandom());
      brPredTaken   = FW'($urandom());
      btbOut        = {rnd_pc(), rnd_pc()};
      @(negedge clk);
      model_outputs(ev, et, etgt);
      chk_group($sformatf("rnd%0d", c), m_pc, ev, (!rst && m_mode == 1));
      @(posedge clk);
      model_step(et, etgt);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
